// File: rtl/noc_params.sv
// rtl/noc_params.sv - shared NoC constants and the output-port encoding
package noc_params;

    // Width of one mesh coordinate (4x4 mesh).
    localparam int DEST_ADDR_SIZE = 2;

    // Router output port. Codes 5..7 are undefined.
    typedef logic [2:0] port_t;

    localparam port_t LOCAL = 3'd0;
    localparam port_t NORTH = 3'd1;
    localparam port_t SOUTH = 3'd2;
    localparam port_t WEST  = 3'd3;
    localparam port_t EAST  = 3'd4;

endpackage

// File: rtl/rc_scheduler_if.sv
// rtl/rc_scheduler_if.sv - VC buffer / shared RC unit / allocator signals of rc_scheduler (optional err_o: RC_SCHED_ERR_EN)
interface rc_scheduler_if #(
    parameter int VC_NUM = 2
);
    import noc_params::*;

    logic [VC_NUM-1:0]                     rc_req_i;
    logic [VC_NUM-1:0][DEST_ADDR_SIZE-1:0] x_dest_i;
    logic [VC_NUM-1:0][DEST_ADDR_SIZE-1:0] y_dest_i;
    logic [VC_NUM-1:0]                     tail_done_i;
    logic [DEST_ADDR_SIZE-1:0]             rc_x_dest_o;
    logic [DEST_ADDR_SIZE-1:0]             rc_y_dest_o;
    port_t                                 rc_out_port_i;
    logic [VC_NUM-1:0]                     grant_o;
    logic [VC_NUM-1:0]                     route_valid_o;
    port_t [VC_NUM-1:0]                    route_o;
`ifdef RC_SCHED_ERR_EN
    logic                                  err_o;

    modport slave (
        input  rc_req_i, x_dest_i, y_dest_i, tail_done_i, rc_out_port_i,
        output rc_x_dest_o, rc_y_dest_o, grant_o, route_valid_o, route_o, err_o
    );
    modport master (
        output rc_req_i, x_dest_i, y_dest_i, tail_done_i, rc_out_port_i,
        input  rc_x_dest_o, rc_y_dest_o, grant_o, route_valid_o, route_o, err_o
    );
`else
    modport slave (
        input  rc_req_i, x_dest_i, y_dest_i, tail_done_i, rc_out_port_i,
        output rc_x_dest_o, rc_y_dest_o, grant_o, route_valid_o, route_o
    );
    modport master (
        output rc_req_i, x_dest_i, y_dest_i, tail_done_i, rc_out_port_i,
        input  rc_x_dest_o, rc_y_dest_o, grant_o, route_valid_o, route_o
    );
`endif

endinterface

// File: rtl/rc_scheduler.sv
// rtl/rc_scheduler.sv - round-robin sharing of one route-computation unit among VCs (optional err_o: RC_SCHED_ERR_EN)
module rc_scheduler #(
    parameter int VC_NUM = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    rc_scheduler_if.slave  bus
);
    import noc_params::*;

    localparam int RR_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    localparam logic S_IDLE   = 1'b0;
    localparam logic S_ROUTED = 1'b1;

    logic [VC_NUM-1:0]         r_state;
    logic [VC_NUM-1:0]         w_state_nxt;
    logic [RR_W-1:0]           r_rr;
    logic [RR_W-1:0]           w_rr_nxt;
    logic [VC_NUM-1:0]         w_elig;
    logic                      w_gnt_any;
    logic [RR_W-1:0]           w_gnt_idx;
    logic [VC_NUM-1:0]         w_grant;
    logic [DEST_ADDR_SIZE-1:0] w_rc_x;
    logic [DEST_ADDR_SIZE-1:0] w_rc_y;
    port_t [VC_NUM-1:0]        r_route;

    // A VC competes only while it has no route; requests from routed VCs are ignored.
    always_comb begin
        w_elig = bus.rc_req_i & ~r_state;
    end

    // Round-robin search starting at r_rr, wrapping explicitly at VC_NUM (need not be a power of two).
    always_comb begin
        logic [RR_W:0] cand;
        cand      = '0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            cand = {1'b0, r_rr} + (RR_W+1)'(i);
            if (cand >= (RR_W+1)'(VC_NUM)) begin
                cand = cand - (RR_W+1)'(VC_NUM);
            end
            if (!w_gnt_any && w_elig[cand[RR_W-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = cand[RR_W-1:0];
            end
        end
        // While reset is asserted nothing may be granted, even combinationally.
        if (!rst_n) begin
            w_gnt_any = 1'b0;
        end
    end

    // State register: per-VC route state and arbitration pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= {VC_NUM{S_IDLE}};
            r_rr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

    // Next state: a grant routes an idle VC, a tail departure frees a routed VC.
    always_comb begin
        w_state_nxt = r_state;
        for (int v = 0; v < VC_NUM; v++) begin
            if (r_state[v] == S_IDLE && w_grant[v]) begin
                w_state_nxt[v] = S_ROUTED;
            end else if (r_state[v] == S_ROUTED && bus.tail_done_i[v]) begin
                w_state_nxt[v] = S_IDLE;
            end
        end
    end

    // Pointer moves just past the winner; with a single VC it stays at zero.
    always_comb begin
        w_rr_nxt = r_rr;
        if (VC_NUM == 1) begin
            w_rr_nxt = '0;
        end else if (w_gnt_any) begin
            w_rr_nxt = (w_gnt_idx == RR_W'(VC_NUM - 1)) ? '0 : w_gnt_idx + RR_W'(1);
        end
    end

    // Outputs: one-hot grant and the winner's destination steered to the shared RC unit.
    always_comb begin
        w_grant = '0;
        w_rc_x  = '0;
        w_rc_y  = '0;
        if (w_gnt_any) begin
            w_grant[w_gnt_idx] = 1'b1;
            w_rc_x             = bus.x_dest_i[w_gnt_idx];
            w_rc_y             = bus.y_dest_i[w_gnt_idx];
        end
    end

    // Capture the RC result for the granted VC; the value persists after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_route <= {VC_NUM{LOCAL}};
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (w_grant[v]) begin
                    r_route[v] <= bus.rc_out_port_i;
                end
            end
        end
    end

    assign bus.grant_o       = w_grant;
    assign bus.rc_x_dest_o   = w_rc_x;
    assign bus.rc_y_dest_o   = w_rc_y;
    assign bus.route_valid_o = r_state;
    assign bus.route_o       = r_route;

`ifdef RC_SCHED_ERR_EN
    logic r_err;
    logic w_port_bad;
    logic w_err_evt;

    // Protocol violations: release of an idle VC, re-request of a routed VC, undefined RC result.
    always_comb begin
        case (bus.rc_out_port_i)
            LOCAL, NORTH, SOUTH, WEST, EAST: w_port_bad = 1'b0;
            default:                         w_port_bad = 1'b1;
        endcase
        w_err_evt = (|(bus.tail_done_i & ~r_state))
                  | (|(bus.rc_req_i & r_state & ~bus.tail_done_i))
                  | (w_gnt_any & w_port_bad);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err_o = r_err;
`endif

endmodule
